// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : spi_pkg
//  Brief    : Shared constants and types for the SPI mode-0 byte receiver.
//  Revision : 1.0 - initial release
// ============================================================================
package spi_pkg;

  // Default SPI word width; the display path downstream assumes 8 bits
  localparam int SPI_DATA_W = 8;

  // Width of the bit counter for the default word width
  localparam int SPI_CNT_W = $clog2(SPI_DATA_W);

  // Receiver state: waiting for chip select, or shifting bits
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

endpackage
`default_nettype wire

// File: rtl/sync_edge_det.sv
`default_nettype none
// ============================================================================
//  Module   : sync_edge_det
//  Brief    : Multi-flop synchronizer for an asynchronous input with
//             registered rising/falling edge pulses in the clk domain.
//  Revision : 1.0 - initial release
// ============================================================================
module sync_edge_det #(
  parameter int SYNC_STAGES = 2,
  parameter bit RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic level_s,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise_q;
  logic                   fall_q;

  // Synchronize the input, keep a delayed copy, and register the edge pulses.
  // Resetting the chain and the delayed copy to the same value means no edge
  // is reported at reset exit unless the pin really differs from RST_VAL.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      prev_q <= RST_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev_q <= sync_q[SYNC_STAGES-1];
      rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
      fall_q <= ~sync_q[SYNC_STAGES-1] & prev_q;
    end
  end

  assign level_s = sync_q[SYNC_STAGES-1];
  assign rise    = rise_q;
  assign fall    = fall_q;

endmodule
`default_nettype wire

// File: rtl/spi_slave_byte_rx.sv
`default_nettype none
// ============================================================================
//  Module   : spi_slave_byte_rx
//  Brief    : SPI mode-0 slave. Assembles MSB-first words, holds the last
//             complete word, and echoes the previous word on miso.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_slave_byte_rx
  import spi_pkg::*;
#(
  parameter int DATA_W      = SPI_DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic [DATA_W-1:0] data_out,
  output logic              rx_valid,
  output logic              frame_err
);

  localparam int               CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  // Synchronized SPI pins
  logic sclk_rise;
  logic sclk_fall;
  logic sclk_level_unused;
  logic cs_rise;
  logic cs_fall;
  logic cs_level_unused;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic mosi_s;

  // Receiver state
  state_e            state_q;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic [CNT_W-1:0]  bit_cnt_d;
  logic [DATA_W-1:0] shift_rx_q;
  logic [DATA_W-1:0] shift_rx_d;
  logic [DATA_W-1:0] tx_hold_q;
  logic [DATA_W-1:0] tx_shift_q;
  logic [DATA_W-1:0] data_out_q;
  logic              rx_valid_q;
  logic              frame_err_q;
  logic              miso_q;
  logic              last_bit;
  logic              byte_done;

  sync_edge_det #(
    .SYNC_STAGES (SYNC_STAGES),
    .RST_VAL     (1'b0)
  ) u_sclk_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (sclk),
    .level_s  (sclk_level_unused),
    .rise     (sclk_rise),
    .fall     (sclk_fall)
  );

  // cs_n chain resets low so a chip select still held low through reset is
  // not mistaken for a new frame start.
  sync_edge_det #(
    .SYNC_STAGES (SYNC_STAGES),
    .RST_VAL     (1'b0)
  ) u_cs_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (cs_n),
    .level_s  (cs_level_unused),
    .rise     (cs_rise),
    .fall     (cs_fall)
  );

  // Bring mosi into the clk domain through a chain as deep as the sclk one
  always_ff @(posedge clk) begin
    if (rst) begin
      mosi_sync_q <= '0;
    end else begin
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    end
  end

  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // Next-state values for the receive shifter and bit counter
  always_comb begin
    last_bit   = (bit_cnt_q == LAST_BIT);
    byte_done  = sclk_rise & last_bit;
    shift_rx_d = {shift_rx_q[DATA_W-2:0], mosi_s};
    bit_cnt_d  = last_bit ? '0 : bit_cnt_q + 1'b1;
  end

  // Frame FSM: sample on sclk rise, drive miso on sclk fall, close on cs_n rise
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_rx_q  <= '0;
      tx_hold_q   <= '0;
      tx_shift_q  <= '0;
      data_out_q  <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      miso_q      <= 1'b0;
    end else begin
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          miso_q <= 1'b0;
          if (cs_fall) begin
            state_q    <= SHIFT;
            bit_cnt_q  <= '0;
            tx_shift_q <= tx_hold_q;
            miso_q     <= tx_hold_q[DATA_W-1];
          end
        end
        SHIFT: begin
          if (sclk_rise) begin
            shift_rx_q <= shift_rx_d;
            bit_cnt_q  <= bit_cnt_d;
          end
          if (byte_done) begin
            // Word complete: publish it and queue it as the next echo word
            data_out_q <= shift_rx_d;
            rx_valid_q <= 1'b1;
            tx_hold_q  <= shift_rx_d;
            tx_shift_q <= shift_rx_d;
          end else if (sclk_fall) begin
            // A fall with the counter at zero follows a word boundary: the
            // freshly loaded word's MSB goes out unshifted.
            if (bit_cnt_q == '0) begin
              miso_q <= tx_shift_q[DATA_W-1];
            end else begin
              tx_shift_q <= tx_shift_q << 1;
              miso_q     <= tx_shift_q[DATA_W-2];
            end
          end
          if (cs_rise) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            miso_q      <= 1'b0;
            // A word completing on this same clk is accepted, not an error
            frame_err_q <= sclk_rise ? ~last_bit : (bit_cnt_q != '0);
          end
        end
        default: begin
          state_q <= IDLE;
          miso_q  <= 1'b0;
        end
      endcase
    end
  end

  assign miso      = miso_q;
  assign data_out  = data_out_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;

endmodule
`default_nettype wire
